// File: rtl/pipe_controller_if.sv
// Bundle between the MIPS-style control pipeline and its datapath.
// Carries the D-stage fields and hazard requests into the controller.
// Carries the per-stage decoded controls back out to the datapath.
// The slave modport is the controller's view; master is the datapath's view.
interface pipe_controller_if #(
    parameter int ALUCTRL_W = 3
);
    logic [5:0]           op;
    logic [5:0]           funct;
    logic                 equalD;
    logic                 stallE;
    logic                 flushE;
    logic                 flushM;

    logic                 pcsrcD;
    logic                 jumpD;
    logic                 branchD;
    logic                 illegalD;

    logic                 regdstE;
    logic                 alusrcE;
    logic                 memtoregE;
    logic                 regwriteE;
    logic                 linkE;
    logic [ALUCTRL_W-1:0] alucontrolE;

    logic                 memwriteM;
    logic                 memtoregM;
    logic                 regwriteM;

    logic                 memtoregW;
    logic                 regwriteW;
    logic                 linkW;

    modport master (
        output op, funct, equalD, stallE, flushE, flushM,
        input  pcsrcD, jumpD, branchD, illegalD,
        input  regdstE, alusrcE, memtoregE, regwriteE, linkE, alucontrolE,
        input  memwriteM, memtoregM, regwriteM,
        input  memtoregW, regwriteW, linkW
    );

    modport slave (
        input  op, funct, equalD, stallE, flushE, flushM,
        output pcsrcD, jumpD, branchD, illegalD,
        output regdstE, alusrcE, memtoregE, regwriteE, linkE, alucontrolE,
        output memwriteM, memtoregM, regwriteM,
        output memtoregW, regwriteW, linkW
    );
endinterface

// File: rtl/pipe_controller.sv
// Control unit for a 5-stage MIPS-style pipeline.
// Decodes op/funct combinationally in D.
// Carries the decoded controls through the E, M and W pipeline registers.
// Optional feature: define PIPE_CTRL_JAL_EN to decode jal (op 000011) with link.
// Without that macro, jal is illegal and linkE/linkW are tied low.
module pipe_controller #(
    parameter int ALUCTRL_W = 3
) (
    input  logic              clka,
    input  logic              rst,
    pipe_controller_if.slave  bus
);
    localparam logic [5:0] opRtype = 6'b000000;
    localparam logic [5:0] opLw    = 6'b100011;
    localparam logic [5:0] opSw    = 6'b101011;
    localparam logic [5:0] opBeq   = 6'b000100;
    localparam logic [5:0] opBne   = 6'b000101;
    localparam logic [5:0] opAddi  = 6'b001000;
    localparam logic [5:0] opAndi  = 6'b001100;
    localparam logic [5:0] opOri   = 6'b001101;
    localparam logic [5:0] opSlti  = 6'b001010;
    localparam logic [5:0] opJ     = 6'b000010;

    localparam logic [2:0] aluAnd = 3'b000;
    localparam logic [2:0] aluOr  = 3'b001;
    localparam logic [2:0] aluAdd = 3'b010;
    localparam logic [2:0] aluSub = 3'b110;
    localparam logic [2:0] aluSlt = 3'b111;

    logic       regWriteD, regDstD, aluSrcD, memToRegD, memWriteD;
    logic       branchD, jumpD, illegalD;
    logic [2:0] aluCtrlD;
`ifdef PIPE_CTRL_JAL_EN
    logic       linkD;
`endif

    // D stage: combinational decode; anything unrecognised becomes an all-zero illegal op
    always_comb begin
        regWriteD = 1'b0;
        regDstD   = 1'b0;
        aluSrcD   = 1'b0;
        memToRegD = 1'b0;
        memWriteD = 1'b0;
        branchD   = 1'b0;
        jumpD     = 1'b0;
        illegalD  = 1'b0;
        aluCtrlD  = 3'b000;
`ifdef PIPE_CTRL_JAL_EN
        linkD     = 1'b0;
`endif
        case (bus.op)
            opRtype: begin
                regWriteD = 1'b1;
                regDstD   = 1'b1;
                case (bus.funct)
                    6'b100000: aluCtrlD = aluAdd;
                    6'b100010: aluCtrlD = aluSub;
                    6'b100100: aluCtrlD = aluAnd;
                    6'b100101: aluCtrlD = aluOr;
                    6'b101010: aluCtrlD = aluSlt;
                    default:   illegalD = 1'b1;
                endcase
            end
            opLw: begin
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                memToRegD = 1'b1;
                aluCtrlD  = aluAdd;
            end
            opSw: begin
                memWriteD = 1'b1;
                aluSrcD   = 1'b1;
                aluCtrlD  = aluAdd;
            end
            opBeq, opBne: begin
                branchD  = 1'b1;
                aluCtrlD = aluSub;
            end
            opAddi: begin regWriteD = 1'b1; aluSrcD = 1'b1; aluCtrlD = aluAdd; end
            opAndi: begin regWriteD = 1'b1; aluSrcD = 1'b1; aluCtrlD = aluAnd; end
            opOri:  begin regWriteD = 1'b1; aluSrcD = 1'b1; aluCtrlD = aluOr;  end
            opSlti: begin regWriteD = 1'b1; aluSrcD = 1'b1; aluCtrlD = aluSlt; end
            opJ:    jumpD = 1'b1;
`ifdef PIPE_CTRL_JAL_EN
            6'b000011: begin
                jumpD     = 1'b1;
                regWriteD = 1'b1;
                linkD     = 1'b1;
            end
`endif
            default: illegalD = 1'b1;
        endcase
        // An illegal instruction must not leak any partially decoded control.
        if (illegalD) begin
            regWriteD = 1'b0;
            regDstD   = 1'b0;
            aluSrcD   = 1'b0;
            memToRegD = 1'b0;
            memWriteD = 1'b0;
            branchD   = 1'b0;
            jumpD     = 1'b0;
            aluCtrlD  = 3'b000;
`ifdef PIPE_CTRL_JAL_EN
            linkD     = 1'b0;
`endif
        end
    end

    // branchD is set only for beq/bne, and op[0] tells them apart.
    assign bus.pcsrcD   = branchD & (bus.op[0] ? ~bus.equalD : bus.equalD);
    assign bus.jumpD    = jumpD;
    assign bus.branchD  = branchD;
    assign bus.illegalD = illegalD;

    // ---- D -> E boundary ----
    logic       regDstE_p1, aluSrcE_p1, memToRegE_p1, regWriteE_p1, memWriteE_p1;
    logic [2:0] aluCtrlE_p1;

    // E register: reset, then bubble on flushE, then hold on stallE
    always_ff @(posedge clka) begin
        if (!rst || bus.flushE) begin
            regDstE_p1   <= 1'b0;
            aluSrcE_p1   <= 1'b0;
            memToRegE_p1 <= 1'b0;
            regWriteE_p1 <= 1'b0;
            memWriteE_p1 <= 1'b0;
            aluCtrlE_p1  <= 3'b000;
        end else if (!bus.stallE) begin
            regDstE_p1   <= regDstD;
            aluSrcE_p1   <= aluSrcD;
            memToRegE_p1 <= memToRegD;
            regWriteE_p1 <= regWriteD;
            memWriteE_p1 <= memWriteD;
            aluCtrlE_p1  <= aluCtrlD;
        end
    end

    assign bus.regdstE     = regDstE_p1;
    assign bus.alusrcE     = aluSrcE_p1;
    assign bus.memtoregE   = memToRegE_p1;
    assign bus.regwriteE   = regWriteE_p1;
    assign bus.alucontrolE = ALUCTRL_W'(aluCtrlE_p1);

    // ---- E -> M boundary ----
    logic memWriteM_p2, memToRegM_p2, regWriteM_p2;

    // M register: a held E instruction must not also advance, so stallE bubbles M
    always_ff @(posedge clka) begin
        if (!rst || bus.flushM || bus.stallE) begin
            memWriteM_p2 <= 1'b0;
            memToRegM_p2 <= 1'b0;
            regWriteM_p2 <= 1'b0;
        end else begin
            memWriteM_p2 <= memWriteE_p1;
            memToRegM_p2 <= memToRegE_p1;
            regWriteM_p2 <= regWriteE_p1;
        end
    end

    assign bus.memwriteM = memWriteM_p2;
    assign bus.memtoregM = memToRegM_p2;
    assign bus.regwriteM = regWriteM_p2;

    // ---- M -> W boundary ----
    logic memToRegW_p3, regWriteW_p3;

    // W register: free-running, never stalled
    always_ff @(posedge clka) begin
        if (!rst) begin
            memToRegW_p3 <= 1'b0;
            regWriteW_p3 <= 1'b0;
        end else begin
            memToRegW_p3 <= memToRegM_p2;
            regWriteW_p3 <= regWriteM_p2;
        end
    end

    assign bus.memtoregW = memToRegW_p3;
    assign bus.regwriteW = regWriteW_p3;

`ifdef PIPE_CTRL_JAL_EN
    logic linkE_p1, linkM_p2, linkW_p3;

    // Link bit follows the same bubble/hold rules as the other controls at each stage
    always_ff @(posedge clka) begin
        if (!rst || bus.flushE)  linkE_p1 <= 1'b0;
        else if (!bus.stallE)    linkE_p1 <= linkD;
        if (!rst || bus.flushM || bus.stallE) linkM_p2 <= 1'b0;
        else                                  linkM_p2 <= linkE_p1;
        if (!rst) linkW_p3 <= 1'b0;
        else      linkW_p3 <= linkM_p2;
    end

    assign bus.linkE = linkE_p1;
    assign bus.linkW = linkW_p3;
`else
    assign bus.linkE = 1'b0;
    assign bus.linkW = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller: directed steps followed by a
// randomized run against a behavioural reference model.
// Honours PIPE_CTRL_JAL_EN so both builds are checked.
module tb_pipe_controller;
    localparam int ALUCTRL_W = 3;

    logic clka = 1'b0;
    logic rst;
    always #5 clka = ~clka;

    pipe_controller_if #(.ALUCTRL_W(ALUCTRL_W)) bus ();

    pipe_controller #(.ALUCTRL_W(ALUCTRL_W)) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct packed {
        logic       rw;
        logic       rd;
        logic       as;
        logic       mr;
        logic       mw;
        logic       br;
        logic       jp;
        logic       lk;
        logic       ill;
        logic [2:0] alu;
    } ctl_t;

    int tests = 0;
    int fails = 0;

    ctl_t mE = '0;
    ctl_t mM = '0;
    ctl_t mW = '0;

    logic [5:0] opList [14] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b000101, 6'b001000, 6'b001100, 6'b001101,
                                6'b001010, 6'b000010, 6'b000011, 6'b000000,
                                6'b111111, 6'b010001};
    logic [5:0] fnList [6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b101010, 6'b000111};

    // Instruction table as a lookup from op/funct to the control set.
    function automatic ctl_t refDecode(input logic [5:0] op, input logic [5:0] fn);
        ctl_t c;
        c = '0;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000: c.alu = 3'b010;
                    6'b100010: c.alu = 3'b110;
                    6'b100100: c.alu = 3'b000;
                    6'b100101: c.alu = 3'b001;
                    6'b101010: c.alu = 3'b111;
                    default:   c.ill = 1'b1;
                endcase
                if (!c.ill) begin c.rw = 1'b1; c.rd = 1'b1; end
            end
            6'b100011: begin c.rw = 1; c.as = 1; c.mr = 1; c.alu = 3'b010; end
            6'b101011: begin c.mw = 1; c.as = 1; c.alu = 3'b010; end
            6'b000100: begin c.br = 1; c.alu = 3'b110; end
            6'b000101: begin c.br = 1; c.alu = 3'b110; end
            6'b001000: begin c.rw = 1; c.as = 1; c.alu = 3'b010; end
            6'b001100: begin c.rw = 1; c.as = 1; c.alu = 3'b000; end
            6'b001101: begin c.rw = 1; c.as = 1; c.alu = 3'b001; end
            6'b001010: begin c.rw = 1; c.as = 1; c.alu = 3'b111; end
            6'b000010: c.jp = 1;
`ifdef PIPE_CTRL_JAL_EN
            6'b000011: begin c.jp = 1; c.rw = 1; c.lk = 1; end
`endif
            default:   c.ill = 1'b1;
        endcase
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // D-stage outputs against the table and the branch-taken rule.
    task automatic checkDec();
        ctl_t d;
        logic taken;
        #1;
        d = refDecode(bus.op, bus.funct);
        taken = (bus.op == 6'b000100 && bus.equalD) || (bus.op == 6'b000101 && !bus.equalD);
        check("decodeD", {bus.pcsrcD, bus.jumpD, bus.branchD, bus.illegalD},
              {taken, d.jp, d.br, d.ill});
    endtask

    task automatic checkPipe();
        check("stageE", {bus.regdstE, bus.alusrcE, bus.memtoregE, bus.regwriteE, bus.linkE, bus.alucontrolE},
              {mE.rd, mE.as, mE.mr, mE.rw, mE.lk, mE.alu});
        check("stageM", {bus.memwriteM, bus.memtoregM, bus.regwriteM}, {mM.mw, mM.mr, mM.rw});
        check("stageW", {bus.memtoregW, bus.regwriteW, bus.linkW}, {mW.mr, mW.rw, mW.lk});
    endtask

    // Advance the model by one clock using the inputs presented now, then clock the DUT.
    task automatic step();
        ctl_t d;
        d = refDecode(bus.op, bus.funct);
        if (!rst) begin
            mE = '0; mM = '0; mW = '0;
        end else begin
            mW = '0;
            mW.mr = mM.mr; mW.rw = mM.rw; mW.lk = mM.lk;
            mM = '0;
            if (!(bus.flushM || bus.stallE)) begin
                mM.mr = mE.mr; mM.mw = mE.mw; mM.rw = mE.rw; mM.lk = mE.lk;
            end
            if (bus.flushE)      mE = '0;
            else if (!bus.stallE) mE = d;
        end
        @(posedge clka);
        #1;
        checkPipe();
    endtask

    function automatic logic [15:0] allPipe();
        return {bus.regdstE, bus.alusrcE, bus.memtoregE, bus.regwriteE, bus.linkE,
                bus.alucontrolE, bus.memwriteM, bus.memtoregM, bus.regwriteM,
                bus.memtoregW, bus.regwriteW, bus.linkW};
    endfunction

    initial begin
        rst        = 1'b0;
        bus.op     = 6'b100011;
        bus.funct  = 6'b000000;
        bus.equalD = 1'b0;
        bus.stallE = 1'b0;
        bus.flushE = 1'b0;
        bus.flushM = 1'b0;

        // Reset held two edges with lw on the decoder.
        step();
        step();
        check("resetAll", allPipe(), 16'h0);
        checkDec();
        rst = 1'b1;
        step();
        check("relMemtoregE", bus.memtoregE, 1);
        check("relAlusrcE", bus.alusrcE, 1);
        check("relAluE", bus.alucontrolE, 3'b010);

        // lw, sw, sub back to back.
        bus.op = 6'b100011; step();
        bus.op = 6'b101011; step();
        bus.op = 6'b000000; bus.funct = 6'b100010; step();
        check("lwRegwriteW", bus.regwriteW, 1);
        check("lwMemtoregW", bus.memtoregW, 1);
        check("swMemwriteM", bus.memwriteM, 1);
        check("subAluE", bus.alucontrolE, 3'b110);

        // Branch resolution.
        bus.op = 6'b000100; bus.equalD = 1'b1; checkDec(); check("beqTaken", bus.pcsrcD, 1);
        bus.op = 6'b000101; bus.equalD = 1'b1; checkDec(); check("bneNotTaken", bus.pcsrcD, 0);
        bus.op = 6'b000101; bus.equalD = 1'b0; checkDec(); check("bneTaken", bus.pcsrcD, 1);
        check("bneBranchD", bus.branchD, 1);

        // addi held in E by a two-cycle stall.
        bus.op = 6'b001000; step();
        check("addiRegwriteE", bus.regwriteE, 1);
        bus.stallE = 1'b1; bus.op = 6'b001101;
        step();
        check("stall1RegwriteM", bus.regwriteM, 0);
        check("stall1AluE", bus.alucontrolE, 3'b010);
        step();
        check("stall2RegwriteM", bus.regwriteM, 0);
        check("stall2RegwriteE", bus.regwriteE, 1);
        bus.stallE = 1'b0;
        step();
        check("releaseRegwriteM", bus.regwriteM, 1);

        // flushE together with stallE while decoding sw.
        bus.op = 6'b101011; bus.flushE = 1'b1; bus.stallE = 1'b1;
        step();
        check("flushStallE", allPipe() >> 7, 9'h0);
        check("flushStallM1", bus.memwriteM, 0);
        bus.flushE = 1'b0; bus.stallE = 1'b0; bus.op = 6'b000000; bus.funct = 6'b100000;
        step();
        check("flushStallM2", bus.memwriteM, 0);

        // jal.
        bus.op = 6'b000011;
        checkDec();
`ifdef PIPE_CTRL_JAL_EN
        check("jalJumpD", bus.jumpD, 1);
        step();
        bus.op = 6'b000000; bus.funct = 6'b100000;
        step();
        step();
        check("jalLinkW", bus.linkW, 1);
`else
        check("jalIllegalD", bus.illegalD, 1);
        check("jalCtlD", {bus.jumpD, bus.branchD, bus.pcsrcD}, 3'b000);
        step();
        check("jalBubbleE", allPipe() >> 7, 9'h0);
`endif

        // Randomized traffic with occasional stalls, flushes and resets.
        for (int i = 0; i < 400; i++) begin
            bus.op     = opList[$urandom_range(0, 13)];
            bus.funct  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fnList[$urandom_range(0, 5)];
            bus.equalD = 1'($urandom);
            bus.stallE = ($urandom_range(0, 4) == 0);
            bus.flushE = ($urandom_range(0, 6) == 0);
            bus.flushM = ($urandom_range(0, 8) == 0);
            rst        = ($urandom_range(0, 24) != 0);
            checkDec();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
